lsu: RTL and testbench
======================

# lsu

Load/store unit consuming the execute-stage address (`alu` result, `rs1 + imm`) and turning it into a word-aligned data-memory transaction. It sits between execute and writeback: it accepts one request at a time, handshakes with data memory, and returns sign/zero-extended load data or a store completion. It also raises an error for misaligned or illegal accesses.

## Interface
- `DATA_WIDTH`, 32, data path width; only 32 is supported.
- `ADDR_WIDTH`, 32, byte address width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  LSU can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_WIDTH  byte address (ALU result).
- `req_wdata`  in  DATA_WIDTH  store data (rs2), right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  valid with `rsp_valid`: misaligned or illegal funct3.
- `mem_valid`  out  1  memory request.
- `mem_ready`  in  1  memory accepts request.
- `mem_we`  out  1  store request.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, low 2 bits 0.
- `mem_wstrb`  out  4  byte enables; 0000 for loads.
- `mem_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DATA_WIDTH  read word.

## Operation
- FSM: IDLE, REQ, WAIT, RESP. `req_ready` = 1 only in IDLE.
- IDLE, `req_valid`: capture `we`, `funct3`, `addr`, `wdata`.
  - Legal and aligned: go to REQ.
  - Error: go to RESP with the error flag set.
- Illegal: funct3 011/110/111 on a load; any funct3 other than 000/001/010 on a store.
- Misaligned: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
- REQ: `mem_valid`=1, all `mem_*` driven from the captured registers and stable until `mem_ready`.
  - On `mem_valid && mem_ready`: a load goes to WAIT; a store goes to RESP.
- WAIT: on `mem_rvalid`, register the extracted data and go to RESP. `mem_rvalid` is ignored in every other state.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no backpressure on the response.
- Store lanes:
  - SB: `wdata` = 4 copies of byte[7:0]; `wstrb` = 0001 << `addr[1:0]`.
  - SH: `wdata` = 2 copies of half[15:0]; `wstrb` = 0011 << `addr[1:0]`.
  - SW: `wstrb` = 1111.
- Load extract: shift `mem_rdata` right by 8*`addr[1:0]`, take 8/16/32 bits, then sign-extend (B, H) or zero-extend (BU, HU).

## Timing
- Reset: state IDLE; `req_ready`=1; all other outputs 0, including `rsp_*` and all `mem_*`.
- Reset mid-operation: the next cycle is IDLE with no `rsp_valid`. A late `mem_rvalid` is dropped.
- Latency is measured from the acceptance edge (cycle 0):
  - Load with `mem_ready` in the REQ cycle and `mem_rvalid` in the first WAIT cycle: `rsp_valid` in cycle 3.
  - Store: `rsp_valid` in cycle 2.
  - Error: `rsp_valid` in cycle 1, and `mem_valid` is never asserted.
- Each cycle of `mem_ready`=0 or `mem_rvalid`=0 adds one cycle of latency.
- `req_ready` is 0 from cycle 1 until the cycle after RESP, so there is one outstanding request maximum.

## Structure
- Shared package `core_pkg` holds:
  - `mem_width_e`: the funct3 codes above;
  - `lsu_state_e`: IDLE/REQ/WAIT/RESP;
  - `WSTRB_W` = 4.
- Sub-module `lsu_align`: combinational store lane replication/strobe generation and load extraction/extension. It is instantiated once and unit-tested alone.
- Top level: FSM plus the capture registers.

## Test plan
- LW at 0x100, `mem_ready` immediate, `mem_rdata`=0xDEADBEEF -> expect:
  - `mem_addr`=0x100, `wstrb`=0000;
  - `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` in cycle 3.
- LB at 0x103 with `mem_rdata`=0x80FF1234 -> `rsp_rdata`=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SH at 0x102, `wdata`=0x0000ABCD -> `mem_addr`=0x100, `wstrb`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1, `rsp_valid` in cycle 2.
- LW at 0x101 -> `rsp_valid` and `rsp_err`=1 in cycle 1, `rsp_rdata`=0, `mem_valid` never 1. Store with funct3=100 -> `rsp_err`=1.
- `mem_ready` held 0 for 5 cycles during SW 0x200 -> `mem_valid`/`addr`/`wdata`/`wstrb` stable, `req_ready`=0, `rsp_valid` 1 cycle after the handshake.
- `rst` pulsed in WAIT, then `mem_rvalid` -> IDLE next cycle, `req_ready`=1, no `rsp_valid`. A following LW completes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: memory access width codes, LSU state encoding and
// the access legality check used when a request is accepted.
package core_pkg;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  localparam int WSTRB_W = 4;

  // Illegal width code for the direction, or address not aligned to the width.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) illegal = !(funct3 inside {MW_B, MW_H, MW_W});
    else    illegal = !(funct3 inside {MW_B, MW_H, MW_W, MW_BU, MW_HU});
    case (funct3)
      MW_H, MW_HU: misaligned = addr_lo[0];
      MW_W:        misaligned = |addr_lo;
      default:     misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes,
// load data extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  we,
  input  mem_width_e            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] st_wdata,
  output logic [WSTRB_W-1:0]    st_wstrb,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    st_wdata = '0;
    st_wstrb = '0;
    case (funct3)
      MW_B: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr_lo;
      end
      MW_H: begin
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = 4'b0011 << addr_lo;
      end
      MW_W: begin
        st_wdata = wdata;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = '0;
        st_wstrb = '0;
      end
    endcase
    if (!we) st_wstrb = '0;
  end

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      MW_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      MW_BU:   ld_data = {24'h0, shifted[7:0]};
      MW_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      MW_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request, word-aligned memory handshake,
// one-cycle response pulse with extended load data or an access error.
module lsu
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WSTRB_W-1:0]    mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state;
  logic                  we_q;
  mem_width_e            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ld_data;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .we       (we_q),
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .wdata    (wdata_q),
    .rdata    (mem_rdata),
    .st_wdata (mem_wdata),
    .st_wstrb (mem_wstrb),
    .ld_data  (ld_data)
  );

  // Memory-side outputs come straight from the capture registers, so they
  // hold steady for the whole REQ phase regardless of mem_ready stalls.
  assign mem_we   = we_q;
  assign mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      we_q      <= 1'b0;
      funct3_q  <= MW_B;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= mem_width_e'(req_funct3);
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (access_err(req_we, req_funct3, req_addr[1:0])) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ST_REQ;
              mem_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (we_q) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ld_data;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic
// against a byte-level reference model of load/store semantics.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of the most recent transaction
  logic        o_got, o_err, o_we, o_unstable, o_rdy_bad, o_after_ok;
  int unsigned o_cyc, o_mv_cnt;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_wstrb;

  // ---------------- reference model ----------------
  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int unsigned o, sz;
    logic [31:0] mask, val;
    o = addr % 4;
    sz = size_of(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    val = (rdata >> (8 * o)) & mask;
    if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
    return val;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned t;
    t = ((32'd1 << size_of(f3)) - 1) << (addr % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(wdata >> (8 * (k % size_of(f3))));
    return r;
  endfunction

  // ---------------- stimulus driver ----------------
  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int unsigned rd_dly, input int unsigned rv_dly);
    int unsigned cyc, rc, wc;
    logic hs, hs_next, first;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    o_got = 0; o_mv_cnt = 0; o_unstable = 0; o_rdy_bad = !req_ready; o_after_ok = 0;
    o_cyc = 0; o_rdata = 'x; o_err = 'x;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; rc = 0; wc = 0; hs = 0; first = 1;
    while (cyc < 60) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom; hs_next = 0;
      if (rsp_valid) begin
        o_got = 1; o_cyc = cyc; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
      if (req_ready) o_rdy_bad = 1;
      if (mem_valid) begin
        o_mv_cnt++;
        if (first) begin
          o_addr = mem_addr; o_wstrb = mem_wstrb; o_wdata = mem_wdata; o_we = mem_we; first = 0;
        end else if (mem_addr !== o_addr || mem_wstrb !== o_wstrb ||
                     mem_wdata !== o_wdata || mem_we !== o_we) begin
          o_unstable = 1;
        end
        if (rc >= rd_dly) begin mem_ready = 1'b1; hs_next = 1; end
        rc++;
      end else if (hs && !we) begin
        if (wc >= rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        wc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs_next) hs = 1;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    o_after_ok = !rsp_valid && req_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      n_fail++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_tests++;
    if ({mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_mem got v=%b we=%b a=%h s=%b d=%h want 0",
               mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
  endtask

  task automatic test_load;
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    n_tests++;
    if (o_addr !== 32'h100 || o_wstrb !== 4'b0000 || o_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_mem got a=%h s=%b we=%b want 100/0000/0", o_addr, o_wstrb, o_we);
    end
    n_tests++;
    if (!o_got || o_cyc != 3 || o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin
      n_fail++; $display("FAIL lw_rsp got cyc=%0d d=%h e=%b want 3/deadbeef/0", o_cyc, o_rdata, o_err);
    end
    n_tests++;
    if (o_rdy_bad || !o_after_ok) begin
      n_fail++; $display("FAIL lw_ready got bad=%b after=%b want 0/1", o_rdy_bad, o_after_ok);
    end
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    n_tests++;
    if (o_rdata !== 32'hFFFFFF80 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL lb got %h want ffffff80", o_rdata);
    end
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    n_tests++;
    if (o_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h want 00000080", o_rdata); end
    do_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
    n_tests++;
    if (o_rdata !== 32'h000080FF) begin n_fail++; $display("FAIL lhu got %h want 000080ff", o_rdata); end
  endtask

  task automatic test_store;
    do_txn(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 0);
    n_tests++;
    if (o_addr !== 32'h100 || o_wstrb !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_we !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_mem got a=%h s=%b d=%h we=%b want 100/1100/abcdabcd/1", o_addr, o_wstrb, o_wdata, o_we);
    end
    n_tests++;
    if (!o_got || o_cyc != 2 || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL sh_rsp got cyc=%0d d=%h e=%b want 2/0/0", o_cyc, o_rdata, o_err);
    end
  endtask

  task automatic test_error;
    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 0);
    n_tests++;
    if (!o_got || o_cyc != 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_mv_cnt != 0) begin
      n_fail++;
      $display("FAIL lw_misaligned got cyc=%0d e=%b d=%h mv=%0d want 1/1/0/0", o_cyc, o_err, o_rdata, o_mv_cnt);
    end
    do_txn(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0);
    n_tests++;
    if (!o_got || o_cyc != 1 || o_err !== 1'b1 || o_mv_cnt != 0) begin
      n_fail++; $display("FAIL st_illegal got cyc=%0d e=%b mv=%0d want 1/1/0", o_cyc, o_err, o_mv_cnt);
    end
  endtask

  task automatic test_stall;
    logic [31:0] wd;
    wd = $urandom;
    do_txn(1'b1, 3'b010, 32'h200, wd, 32'h0, 5, 0);
    n_tests++;
    if (o_unstable || o_rdy_bad || o_mv_cnt != 6) begin
      n_fail++; $display("FAIL sw_stall got unstable=%b rdybad=%b mv=%0d want 0/0/6", o_unstable, o_rdy_bad, o_mv_cnt);
    end
    n_tests++;
    if (o_addr !== 32'h200 || o_wstrb !== 4'b1111 || o_wdata !== wd) begin
      n_fail++; $display("FAIL sw_mem got a=%h s=%b d=%h want 200/1111/%h", o_addr, o_wstrb, o_wdata, wd);
    end
    n_tests++;
    if (!o_got || o_cyc != 7 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL sw_latency got cyc=%0d e=%b want 7/0", o_cyc, o_err);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got rdy=%b rsp=%b mv=%b want 1/0/0", req_ready, rsp_valid, mem_valid);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_late_rvalid got rsp=%b rdy=%b want 0/1", rsp_valid, req_ready);
    end
    rd = $urandom;
    do_txn(1'b0, 3'b010, 32'h300, 32'h0, rd, 0, 0);
    n_tests++;
    if (!o_got || o_cyc != 3 || o_rdata !== rd || o_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_then_lw got cyc=%0d d=%h e=%b want 3/%h/0", o_cyc, o_rdata, o_err, rd);
    end
  endtask

  task automatic test_random;
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd, e_rdata;
    int unsigned rdl, rvl, e_cyc;
    for (int i = 0; i < 150; i++) begin
      we = 1'(i % 2 == 0 ? $urandom_range(0, 1) : 0);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; rd = $urandom;
      rdl = $urandom_range(0, 3); rvl = $urandom_range(0, 3);
      e_err = model_err(we, f3, addr);
      e_rdata = (e_err || we) ? 32'h0 : model_load(f3, addr, rd);
      e_cyc = e_err ? 1 : (we ? 2 + rdl : 3 + rdl + rvl);
      do_txn(we, f3, addr, wd, rd, rdl, rvl);
      n_tests++;
      if (!o_got || o_cyc != e_cyc || o_err !== e_err || o_rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d] we=%b f3=%b a=%h got cyc=%0d e=%b d=%h want %0d/%b/%h",
                 i, we, f3, addr, o_cyc, o_err, o_rdata, e_cyc, e_err, e_rdata);
      end
      n_tests++;
      if (o_mv_cnt != (e_err ? 0 : rdl + 1) || o_unstable || o_rdy_bad || !o_after_ok) begin
        n_fail++;
        $display("FAIL rand_hs[%0d] got mv=%0d unstable=%b rdybad=%b after=%b want %0d/0/0/1",
                 i, o_mv_cnt, o_unstable, o_rdy_bad, o_after_ok, e_err ? 0 : rdl + 1);
      end
      if (!e_err) begin
        n_tests++;
        if (o_addr !== {addr[31:2], 2'b00} || o_we !== we ||
            o_wstrb !== (we ? model_wstrb(f3, addr) : 4'b0000) ||
            (we && o_wdata !== model_wdata(f3, wd))) begin
          n_fail++;
          $display("FAIL rand_mem[%0d] f3=%b a=%h got a=%h we=%b s=%b d=%h want s=%b d=%h",
                   i, f3, addr, o_addr, o_we, o_wstrb, o_wdata,
                   we ? model_wstrb(f3, addr) : 4'b0000, model_wdata(f3, wd));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_store;
    test_error;
    test_stall;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
